// File: rtl/hazard_forward_pc.sv
// Hazard control for the 5-stage RV32 pipeline: EX operand forwarding,
// load-use stall/flush generation and the enable-gated fetch PC register.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   rs1D, rs2D          decode-stage source registers (load-use check)
//   rs1E, rs2E          execute-stage source registers (forward select)
//   rdE, rdM, rdW       destination registers in E / M / W
//   memtoregE           E-stage instruction is a load
//   writesregM/W        M / W instruction writes its rd
//   pauseD              decode halt marker, freezes the PC
//   pcnext              next PC value
//   srcaE, srcbE        register-file operands held in E
//   aluoutM, resultW    forwarding sources from M and W
//   pc                  registered fetch PC
//   stallF, stallD      hold fetch / hold the F->D register
//   flushE              bubble the D->E register
//   forwardAE/BE        operand select codes (10 = M, 01 = W, 00 = reg)
//   srcaFwd, srcbFwd    forwarded operands
//   stall_count         load-use stall cycle counter, saturating
//                       (present only when STALL_COUNT_EN is defined)
//
// Optional feature macro: STALL_COUNT_EN
module hazard_forward_pc #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1D,
    input  logic [4:0]      rs2D,
    input  logic [4:0]      rs1E,
    input  logic [4:0]      rs2E,
    input  logic [4:0]      rdE,
    input  logic [4:0]      rdM,
    input  logic [4:0]      rdW,
    input  logic            memtoregE,
    input  logic            writesregM,
    input  logic            writesregW,
    input  logic            pauseD,
    input  logic [XLEN-1:0] pcnext,
    input  logic [XLEN-1:0] srcaE,
    input  logic [XLEN-1:0] srcbE,
    input  logic [XLEN-1:0] aluoutM,
    input  logic [XLEN-1:0] resultW,
    output logic [XLEN-1:0] pc,
    output logic            stallF,
    output logic            stallD,
    output logic            flushE,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic [XLEN-1:0] srcaFwd,
    output logic [XLEN-1:0] srcbFwd
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]     stall_count
`endif
);

    logic [XLEN-1:0] r_pc;
    logic            w_lwstall;

    // M outranks W so the youngest in-flight value is used; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] src,
        input logic [XLEN-1:0] m_val,
        input logic [XLEN-1:0] w_val
    );
        case (sel)
            2'b10:   return m_val;
            2'b01:   return w_val;
            default: return src;
        endcase
    endfunction

    assign forwardAE = fwd_sel(rs1E, rdM, writesregM, rdW, writesregW);
    assign forwardBE = fwd_sel(rs2E, rdM, writesregM, rdW, writesregW);

    assign srcaFwd = fwd_mux(forwardAE, srcaE, aluoutM, resultW);
    assign srcbFwd = fwd_mux(forwardBE, srcbE, aluoutM, resultW);

    // A load in E cannot feed D's operands until it reaches W,
    // so decode and fetch hold one cycle while E gets a bubble.
    assign w_lwstall = memtoregE && (rdE != 5'd0)
                       && ((rdE == rs1D) || (rdE == rs2D));

    assign stallF = w_lwstall;
    assign stallD = w_lwstall;
    assign flushE = w_lwstall;

    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= PC_RESET;
        else if (!w_lwstall && !pauseD)
            r_pc <= pcnext;
    end

    assign pc = r_pc;

`ifdef STALL_COUNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_lwstall && r_stall_cnt != 32'hFFFF_FFFF)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_forward_pc.sv
// Directed testbench for hazard_forward_pc.
// Inputs change on the falling edge; outputs are checked #1 later or #1 after a rising edge.
module tb_hazard_forward_pc;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        memtoregE, writesregM, writesregW, pauseD;
    logic [31:0] pcnext, srcaE, srcbE, aluoutM, resultW;
    logic [31:0] pc, srcaFwd, srcbFwd;
    logic        stallF, stallD, flushE;
    logic [1:0]  forwardAE, forwardBE;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_forward_pc dut (
        .clk        (clk),
        .reset      (reset),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .rdE        (rdE),
        .rdM        (rdM),
        .rdW        (rdW),
        .memtoregE  (memtoregE),
        .writesregM (writesregM),
        .writesregW (writesregW),
        .pauseD     (pauseD),
        .pcnext     (pcnext),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .aluoutM    (aluoutM),
        .resultW    (resultW),
        .pc         (pc),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushE     (flushE),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .srcaFwd    (srcaFwd),
        .srcbFwd    (srcbFwd)
`ifdef STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    task automatic chk_stall(input string name, input logic exp);
        total++;
        if ({stallF, stallD, flushE} !== {3{exp}}) begin
            bad++;
            $display("FAIL %s: stallF/stallD/flushE=%b%b%b expected %b%b%b",
                     name, stallF, stallD, flushE, exp, exp, exp);
        end
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp);
        total++;
        if (pc !== exp) begin
            bad++;
            $display("FAIL %s: pc=%h expected %h", name, pc, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset  = 1'b1;
        pcnext = 32'h40;
        edge_settle();
        chk_pc("reset_pc", 32'h0);
        @(negedge clk);
        reset  = 1'b0;
        pcnext = 32'h4;
        edge_settle();
        chk_pc("release_pc", 32'h4);
    endtask

    task automatic test_forward();
        @(negedge clk);
        rs1E = 5'd5; rdM = 5'd5; rdW = 5'd5;
        writesregM = 1'b1; writesregW = 1'b1;
        srcaE = 32'd99; aluoutM = 32'd11; resultW = 32'd22;
        #1;
        total++;
        if (forwardAE !== 2'b10 || srcaFwd !== 32'd11) begin
            bad++;
            $display("FAIL fwdA_M: fwd=%b val=%0d expected 10/11",
                     forwardAE, srcaFwd);
        end
        writesregM = 1'b0;
        #1;
        total++;
        if (forwardAE !== 2'b01 || srcaFwd !== 32'd22) begin
            bad++;
            $display("FAIL fwdA_W: fwd=%b val=%0d expected 01/22",
                     forwardAE, srcaFwd);
        end
        writesregW = 1'b0;
        #1;
        total++;
        if (forwardAE !== 2'b00 || srcaFwd !== 32'd99) begin
            bad++;
            $display("FAIL fwdA_none: fwd=%b val=%0d expected 00/99",
                     forwardAE, srcaFwd);
        end
        rs2E = 5'd0; rdM = 5'd0; writesregM = 1'b1;
        srcbE = 32'h1234;
        #1;
        total++;
        if (forwardBE !== 2'b00 || srcbFwd !== 32'h1234) begin
            bad++;
            $display("FAIL fwdB_x0: fwd=%b val=%h expected 00/1234",
                     forwardBE, srcbFwd);
        end
        rs2E = 5'd9; rdW = 5'd9; writesregW = 1'b1; rdM = 5'd3;
        #1;
        total++;
        if (forwardBE !== 2'b01 || srcbFwd !== 32'd22) begin
            bad++;
            $display("FAIL fwdB_W: fwd=%b val=%0d expected 01/22",
                     forwardBE, srcbFwd);
        end
        rdM = 5'd9; writesregM = 1'b0; writesregW = 1'b1; rdW = 5'd0;
        #1;
        total++;
        if (forwardBE !== 2'b00 || srcbFwd !== 32'h1234) begin
            bad++;
            $display("FAIL fwdB_none: fwd=%b val=%h expected 00/1234",
                     forwardBE, srcbFwd);
        end
        writesregM = 1'b0; writesregW = 1'b0;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        memtoregE = 1'b1; rdE = 5'd7; rs1D = 5'd1; rs2D = 5'd7;
        pcnext = 32'h8;
        #1;
        chk_stall("lw_rs2", 1'b1);
        edge_settle();
        chk_pc("lw_hold", 32'h4);
        @(negedge clk);
        rs1D = 5'd7;
        #1;
        chk_stall("lw_both", 1'b1);
        rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
        #1;
        chk_stall("lw_x0", 1'b0);
        memtoregE = 1'b0; rdE = 5'd7; rs1D = 5'd7;
        #1;
        chk_stall("not_load", 1'b0);
        edge_settle();
        chk_pc("lw_release", 32'h8);
        rs1D = 5'd0;
    endtask

    task automatic test_pause();
        @(negedge clk);
        pauseD = 1'b1;
        pcnext = 32'h100;
        for (int i = 0; i < 3; i++) begin
            edge_settle();
            chk_pc("pause_hold", 32'h8);
        end
        @(negedge clk);
        memtoregE = 1'b1; rdE = 5'd4; rs1D = 5'd4;
        edge_settle();
        chk_pc("pause_and_stall", 32'h8);
        @(negedge clk);
        memtoregE = 1'b0; pauseD = 1'b0;
        edge_settle();
        chk_pc("pause_release", 32'h100);
    endtask

    task automatic test_reset_override();
        @(negedge clk);
        memtoregE = 1'b1; rdE = 5'd4; rs1D = 5'd4;
        pauseD = 1'b1; reset = 1'b1; pcnext = 32'h200;
        edge_settle();
        chk_pc("reset_overrides", 32'h0);
        @(negedge clk);
        reset = 1'b0; memtoregE = 1'b0; pauseD = 1'b0;
        edge_settle();
        chk_pc("after_override", 32'h200);
    endtask

`ifdef STALL_COUNT_EN
    task automatic test_stall_count();
        @(negedge clk);
        reset = 1'b1; memtoregE = 1'b0;
        edge_settle();
        total++;
        if (stall_count !== 32'd0) begin
            bad++;
            $display("FAIL cnt_reset: cnt=%0d expected 0", stall_count);
        end
        @(negedge clk);
        reset = 1'b0; memtoregE = 1'b1; rdE = 5'd6; rs2D = 5'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        memtoregE = 1'b0;
        edge_settle();
        total++;
        if (stall_count !== 32'd3) begin
            bad++;
            $display("FAIL cnt_three: cnt=%0d expected 3", stall_count);
        end
        @(negedge clk);
        reset = 1'b1;
        edge_settle();
        total++;
        if (stall_count !== 32'd0) begin
            bad++;
            $display("FAIL cnt_clear: cnt=%0d expected 0", stall_count);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0;
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
        rdE = '0; rdM = '0; rdW = '0;
        memtoregE = 1'b0; writesregM = 1'b0; writesregW = 1'b0;
        pauseD = 1'b0;
        pcnext = '0; srcaE = '0; srcbE = '0;
        aluoutM = '0; resultW = '0;

        test_reset();
        test_forward();
        test_load_use();
        test_pause();
        test_reset_override();
`ifdef STALL_COUNT_EN
        test_stall_count();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
